// File: rtl/byte_accumulator_pkg.sv
// Shared definitions for the byte accumulator: state encoding, datapath widths
// and the carry-loss helper.
package byte_accumulator_pkg;

    localparam int SUM_WIDTH     = 16;
    localparam int OPERAND_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // An unsigned add of a non-negative operand lost its carry iff the result shrank.
    function automatic logic add_wrapped(
        input logic [SUM_WIDTH-1:0] before_value,
        input logic [SUM_WIDTH-1:0] after_value
    );
        return (after_value < before_value);
    endfunction

endpackage

// File: rtl/Adder.sv
// Combinational adder: zero-extends an 8-bit operand and adds it to a 16-bit
// running value, wrapping modulo 2^16.
module Adder
    import byte_accumulator_pkg::*;
(
    input  logic [OPERAND_WIDTH-1:0] new_operand,
    input  logic [SUM_WIDTH-1:0]     current_value,
    output logic [SUM_WIDTH-1:0]     output_value
);

    assign output_value = current_value
                        + {{(SUM_WIDTH-OPERAND_WIDTH){1'b0}}, new_operand};

endmodule

// File: rtl/byte_accumulator.sv
// Streams a block of bytes through Adder, keeps the running total and a sticky
// carry-loss flag, and presents the final sum on a valid/ready result port.
module byte_accumulator
    import byte_accumulator_pkg::*;
#(
    parameter int LEN_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [LEN_WIDTH-1:0]     block_len,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [OPERAND_WIDTH-1:0] in_data,
    output logic                     sum_valid,
    input  logic                     sum_ready,
    output logic [SUM_WIDTH-1:0]     sum_out,
    output logic                     wrapped,
    output logic                     busy
);

    state_t                 state_r;
    state_t                 state_next_s;
    logic [LEN_WIDTH-1:0]   cnt_r;
    logic [LEN_WIDTH-1:0]   cnt_next_s;
    logic [SUM_WIDTH-1:0]   acc_r;
    logic [SUM_WIDTH-1:0]   acc_next_s;
    logic                   wrapped_r;
    logic                   wrapped_next_s;
    logic [SUM_WIDTH-1:0]   add_result_s;

    Adder adder0 (
        .new_operand   (in_data),
        .current_value (acc_r),
        .output_value  (add_result_s)
    );

    // Handshake and status flags depend on state alone.
    assign in_ready  = (state_r == ST_ACCUM);
    assign sum_valid = (state_r == ST_DONE);
    assign busy      = (state_r != ST_IDLE);
    assign sum_out   = acc_r;
    assign wrapped   = wrapped_r;

    // Next-state and datapath update for the IDLE/ACCUM/DONE sequence.
    always_comb begin
        state_next_s   = state_r;
        cnt_next_s     = cnt_r;
        acc_next_s     = acc_r;
        wrapped_next_s = wrapped_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    acc_next_s     = {SUM_WIDTH{1'b0}};
                    wrapped_next_s = 1'b0;
                    if (block_len != {LEN_WIDTH{1'b0}}) begin
                        cnt_next_s   = block_len;
                        state_next_s = ST_ACCUM;
                    end else begin
                        state_next_s = ST_DONE;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ACCUM: begin
                if (in_valid) begin
                    acc_next_s     = add_result_s;
                    cnt_next_s     = cnt_r - LEN_WIDTH'(1);
                    wrapped_next_s = wrapped_r | add_wrapped(acc_r, add_result_s);
                    if (cnt_r == LEN_WIDTH'(1)) begin
                        state_next_s = ST_DONE;
                    end else begin
                        state_next_s = ST_ACCUM;
                    end
                end else begin
                    state_next_s = ST_ACCUM;
                end
            end
            ST_DONE: begin
                // A start coinciding with the handshake is dropped on purpose.
                if (sum_ready) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_DONE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State, counter, accumulator and flag registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            cnt_r     <= {LEN_WIDTH{1'b0}};
            acc_r     <= {SUM_WIDTH{1'b0}};
            wrapped_r <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            cnt_r     <= cnt_next_s;
            acc_r     <= acc_next_s;
            wrapped_r <= wrapped_next_s;
        end
    end

endmodule

// File: tb/tb_byte_accumulator.sv
// Self-checking bench for byte_accumulator: directed scenarios plus randomized
// blocks compared against a plain-arithmetic model of the block sum.
module tb_byte_accumulator;

    localparam int LW = 9;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [LW-1:0] block_len;
    logic          in_valid;
    logic          in_ready;
    logic [7:0]    in_data;
    logic          sum_valid;
    logic          sum_ready;
    logic [15:0]   sum_out;
    logic          wrapped;
    logic          busy;

    int checks   = 0;
    int failures = 0;

    logic [7:0] blk [0:511];

    byte_accumulator #(.LEN_WIDTH(LW)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .block_len (block_len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .sum_valid (sum_valid),
        .sum_ready (sum_ready),
        .sum_out   (sum_out),
        .wrapped   (wrapped),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // Reference: true integer sum of the block; the port shows it mod 2^16.
    function automatic int model_total(input int n);
        int s = 0;
        for (int i = 0; i < n; i++) s += int'(blk[i]);
        return s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int len);
        start     = 1'b1;
        block_len = LW'(len);
        tick();
        start     = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d, input int gap);
        int   budget;
        logic acc;
        in_valid = 1'b0;
        repeat (gap) begin
            in_data = 8'($urandom);
            tick();
        end
        in_valid = 1'b1;
        in_data  = d;
        budget   = 20;
        acc      = 1'b0;
        while (!acc && budget > 0) begin
            acc = in_ready;
            tick();
            budget--;
        end
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        if (!acc) begin
            checks++;
            failures++;
            $display("FAIL send_byte_timeout: in_ready=0 expected 1 within 20 cycles");
        end
    endtask

    task automatic run_block(input int len, input int gmax);
        do_start(len);
        for (int i = 0; i < len; i++) send_byte(blk[i], int'($urandom_range(gmax, 0)));
    endtask

    task automatic handshake();
        sum_ready = 1'b1;
        tick();
        sum_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; block_len = '0; in_valid = 1'b0;
        in_data = 8'h00; sum_ready = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
        tick();
        checks++;
        if ({in_ready, sum_valid, busy, wrapped, sum_out} !== 20'h0) begin
            failures++;
            $display("FAIL reset_outputs: rdy=%b vld=%b busy=%b wrap=%b sum=%h expected all 0",
                     in_ready, sum_valid, busy, wrapped, sum_out);
        end
    endtask

    task automatic test_single();
        blk[0] = 8'h01;
        do_start(1);
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL single_busy: busy=%b in_ready=%b expected 1 1", busy, in_ready);
        end
        send_byte(blk[0], 0);
        checks++;
        if (sum_valid !== 1'b1 || sum_out !== 16'h0001 || wrapped !== 1'b0) begin
            failures++;
            $display("FAIL single_sum: vld=%b sum=%h wrap=%b expected 1 0001 0", sum_valid, sum_out, wrapped);
        end
        handshake();
        checks++;
        if (busy !== 1'b0 || sum_valid !== 1'b0 || sum_out !== 16'h0001) begin
            failures++;
            $display("FAIL single_idle: busy=%b vld=%b sum=%h expected 0 0 0001", busy, sum_valid, sum_out);
        end
    endtask

    task automatic test_gaps();
        do_start(2);
        send_byte(8'h42, 0);
        for (int i = 0; i < 3; i++) begin
            in_data = 8'($urandom);
            tick();
            checks++;
            if (in_ready !== 1'b1 || sum_valid !== 1'b0) begin
                failures++;
                $display("FAIL gap_ready: in_ready=%b vld=%b expected 1 0", in_ready, sum_valid);
            end
        end
        send_byte(8'h42, 0);
        checks++;
        if (sum_valid !== 1'b1 || sum_out !== 16'h0084) begin
            failures++;
            $display("FAIL gap_sum: vld=%b sum=%h expected 1 0084", sum_valid, sum_out);
        end
        handshake();
    endtask

    task automatic test_len255();
        for (int i = 0; i < 255; i++) blk[i] = 8'hFF;
        run_block(255, 0);
        checks++;
        if (sum_valid !== 1'b1 || sum_out !== 16'hFE01 || wrapped !== 1'b0) begin
            failures++;
            $display("FAIL len255_sum: vld=%b sum=%h wrap=%b expected 1 fe01 0", sum_valid, sum_out, wrapped);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (sum_valid !== 1'b1 || sum_out !== 16'hFE01) begin
                failures++;
                $display("FAIL len255_hold: vld=%b sum=%h expected 1 fe01", sum_valid, sum_out);
            end
        end
        handshake();
    endtask

    task automatic test_len258();
        for (int i = 0; i < 258; i++) blk[i] = 8'hFF;
        run_block(258, 0);
        checks++;
        if (sum_out !== 16'h00FE || wrapped !== 1'b1) begin
            failures++;
            $display("FAIL len258_sum: sum=%h wrap=%b expected 00fe 1", sum_out, wrapped);
        end
        handshake();
    endtask

    task automatic test_zero_len();
        do_start(0);
        checks++;
        if (sum_valid !== 1'b1 || sum_out !== 16'h0000 || wrapped !== 1'b0 ||
            busy !== 1'b1 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL zero_len: vld=%b sum=%h wrap=%b busy=%b rdy=%b expected 1 0000 0 1 0",
                     sum_valid, sum_out, wrapped, busy, in_ready);
        end
        sum_ready = 1'b1; start = 1'b1; block_len = LW'(5);
        tick();
        sum_ready = 1'b0; start = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL start_with_ack: busy=%b expected 0", busy);
        end
        tick();
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL start_dropped: busy=%b expected 0", busy);
        end
    endtask

    task automatic test_start_ignored();
        int total;
        for (int i = 0; i < 3; i++) blk[i] = 8'($urandom);
        total = model_total(3);
        do_start(3);
        send_byte(blk[0], 0);
        start = 1'b1; block_len = LW'(1);
        tick();
        start = 1'b0;
        send_byte(blk[1], 0);
        checks++;
        if (sum_valid !== 1'b0) begin
            failures++;
            $display("FAIL start_in_accum: vld=%b expected 0 after 2 of 3 bytes", sum_valid);
        end
        send_byte(blk[2], 0);
        checks++;
        if (sum_valid !== 1'b1 || sum_out !== 16'(total)) begin
            failures++;
            $display("FAIL start_in_accum_sum: vld=%b sum=%h expected 1 %h", sum_valid, sum_out, 16'(total));
        end
        handshake();
    endtask

    task automatic test_reset_mid();
        do_start(5);
        for (int i = 0; i < 3; i++) send_byte(8'($urandom), 0);
        #1 reset = 1'b1;
        #1;
        checks++;
        if ({in_ready, sum_valid, busy, wrapped, sum_out} !== 20'h0) begin
            failures++;
            $display("FAIL reset_mid: rdy=%b vld=%b busy=%b wrap=%b sum=%h expected all 0",
                     in_ready, sum_valid, busy, wrapped, sum_out);
        end
        tick();
        reset = 1'b0;
        tick();
        blk[0] = 8'h10; blk[1] = 8'h20;
        run_block(2, 1);
        checks++;
        if (sum_valid !== 1'b1 || sum_out !== 16'h0030 || wrapped !== 1'b0) begin
            failures++;
            $display("FAIL reset_fresh: vld=%b sum=%h wrap=%b expected 1 0030 0", sum_valid, sum_out, wrapped);
        end
        handshake();
    endtask

    task automatic test_back_to_back();
        int len, total, dly;
        for (int b = 0; b < 7; b++) begin
            if (b == 6) begin
                len = 300;
                for (int i = 0; i < len; i++) blk[i] = 8'($urandom_range(255, 200));
            end else begin
                len = int'($urandom_range(20, 1));
                for (int i = 0; i < len; i++) blk[i] = 8'($urandom);
            end
            total = model_total(len);
            run_block(len, 2);
            checks++;
            if (sum_valid !== 1'b1 || sum_out !== 16'(total) || wrapped !== (total > 65535)) begin
                failures++;
                $display("FAIL b2b_sum[%0d]: vld=%b sum=%h wrap=%b expected 1 %h %b",
                         b, sum_valid, sum_out, wrapped, 16'(total), (total > 65535));
            end
            dly = int'($urandom_range(3, 0));
            for (int i = 0; i < dly; i++) begin
                tick();
                checks++;
                if (sum_valid !== 1'b1 || sum_out !== 16'(total)) begin
                    failures++;
                    $display("FAIL b2b_hold[%0d]: vld=%b sum=%h expected 1 %h", b, sum_valid, sum_out, 16'(total));
                end
            end
            handshake();
            checks++;
            if (busy !== 1'b0 || sum_out !== 16'(total)) begin
                failures++;
                $display("FAIL b2b_idle[%0d]: busy=%b sum=%h expected 0 %h", b, busy, sum_out, 16'(total));
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_gaps();
        test_len255();
        test_len258();
        test_zero_len();
        test_start_ignored();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
